// File: rtl/barrel_unshifter_pkg.sv
// Shared definitions for the barrel un-shifter: default width, the amount
// width derivation and the per-stage record layout.
package barrel_unshifter_pkg;

  localparam int WIDTH_DEF = 8;

  // Rotate-amount width for a given data width (never below one bit).
  function automatic int amt_w_of(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam int AMT_W_DEF = amt_w_of(WIDTH_DEF);

  // One pipeline stage's contents at the default width.
  typedef struct packed {
    logic [WIDTH_DEF-1:0] word;
    logic [AMT_W_DEF-1:0] amt;
    logic                 valid;
  } stage_t;

endpackage

// File: rtl/barrel_unshifter_rotl_stage.sv
// One registered conditional left-rotate stage: rotates by 2^K when bit K of
// the carried amount is set, otherwise passes the word through. The stage
// accepts a new entry whenever it is empty or its successor is taking the
// current one, and holds otherwise.
module rotl_stage
  import barrel_unshifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = amt_w_of(WIDTH),
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] prev_word,
  input  logic [AMT_W-1:0] prev_amt,
  input  logic             prev_valid,
  input  logic             next_load,
  output logic             load,
  output logic [WIDTH-1:0] word,
  output logic [AMT_W-1:0] amt,
  output logic             valid
);

  localparam int STEP = 1 << K;

  // Left rotate by STEP: take a WIDTH-wide window out of the doubled word.
  function automatic logic [WIDTH-1:0] rotl_step(input logic [WIDTH-1:0] w);
    logic [2*WIDTH-1:0] dbl;
    dbl = {w, w};
    return dbl[2*WIDTH-1-STEP -: WIDTH];
  endfunction

  assign load = ~valid | next_load;

  // Stage register: clear on reset, capture on load, hold under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word  <= '0;
      amt   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      word  <= prev_amt[K] ? rotl_step(prev_word) : prev_word;
      amt   <= prev_amt;
      valid <= prev_valid;
    end
  end

endmodule

// File: rtl/barrel_unshifter.sv
// Pipelined left rotator that undoes the team right-rotator: out_data is
// in_data rotated left by in_amt, AMT_W cycles later, with valid/ready flow
// control and full backpressure through every stage.
module barrel_unshifter
  import barrel_unshifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = amt_w_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AMT_W-1:0] out_amt
);

  if ((WIDTH < 2) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $error("barrel_unshifter: WIDTH must be a power of two, at least 2");
  end

  // Index 0 is the upstream input; index k+1 is the register of stage k.
  logic [WIDTH-1:0] word_p [AMT_W+1];
  logic [AMT_W-1:0] amt_p  [AMT_W+1];
  logic             vld_p  [AMT_W+1];
  // load_p[k] is stage k's load; load_p[AMT_W] is the downstream acceptance.
  logic             load_p [AMT_W+1];

  assign word_p[0]     = in_data;
  assign amt_p[0]      = in_amt;
  assign vld_p[0]      = in_valid;
  assign load_p[AMT_W] = out_ready;

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    rotl_stage #(
      .WIDTH (WIDTH),
      .AMT_W (AMT_W),
      .K     (k)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .prev_word  (word_p[k]),
      .prev_amt   (amt_p[k]),
      .prev_valid (vld_p[k]),
      .next_load  (load_p[k+1]),
      .load       (load_p[k]),
      .word       (word_p[k+1]),
      .amt        (amt_p[k+1]),
      .valid      (vld_p[k+1])
    );
  end

  // Held high during reset so upstream never sees a stall while the
  // pipeline is being cleared; anything offered then is discarded.
  assign in_ready  = load_p[0] | ~rst_n;

  assign out_data  = word_p[AMT_W];
  assign out_amt   = amt_p[AMT_W];
  assign out_valid = vld_p[AMT_W];

endmodule

// File: tb/tb_barrel_unshifter.sv
// Self-checking bench for barrel_unshifter at the default 8-bit width.
module tb_barrel_unshifter;
  import barrel_unshifter_pkg::*;

  localparam int W  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [AW-1:0] in_amt = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [AW-1:0] out_amt;

  int            n_chk = 0;
  int            n_err = 0;
  int            cyc = 0;
  logic          lat_chk = 1'b0;
  logic [W-1:0]  drv_exp = '0;
  stage_t        sb_q [$];
  int            cyc_q [$];
  stage_t        sb_e;
  int            sb_c;
  logic          rnd_done = 1'b0;

  barrel_unshifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_amt   (out_amt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: out[i] = d[(i - a) mod W]
  function automatic logic [W-1:0] rotl_model(input logic [W-1:0] d, input int a);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = d[(i - a + W) % W];
    return r;
  endfunction

  // Team right-rotator: out[i] = d[(i + a) mod W]
  function automatic logic [W-1:0] rotr_model(input logic [W-1:0] d, input int a);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = d[(i + a) % W];
    return r;
  endfunction

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      cyc_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          sb_e = sb_q.pop_front();
          sb_c = cyc_q.pop_front();
          chk("out_data", 32'(out_data), 32'(sb_e.word));
          chk("out_amt", 32'(out_amt), 32'(sb_e.amt));
          if (lat_chk) chk("latency", 32'(cyc - sb_c), 32'(AW));
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back('{word: drv_exp, amt: in_amt, valid: 1'b1});
        cyc_q.push_back(cyc);
      end
    end
  end

  task automatic wait_acc();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input int a, input logic [W-1:0] e);
    in_data  = d;
    in_amt   = AW'(a);
    drv_exp  = e;
    in_valid = 1'b1;
    wait_acc();
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    chk("drain", 32'(sb_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] stream_tbl [8] = '{8'hA5, 8'h4B, 8'h96, 8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2};

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state, observed during and after reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_out_data", 32'(out_data), 32'd0);
    chk("post_rst_out_amt", 32'(out_amt), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single word: 0x81 rotated left by 1 -> 0x03, latency 3.
    lat_chk = 1'b1;
    send(8'h81, 1, 8'h03);
    drain();

    // Stream 0xA5 with amounts 0..7 back to back.
    for (int a = 0; a < 8; a++) send(8'hA5, a, stream_tbl[a]);
    drain();

    // Inverse of the right-rotator over every word and amount.
    for (int d = 0; d < 256; d++)
      for (int a = 0; a < 8; a++)
        send(rotr_model(W'(d), a), a, W'(d));
    drain();
    lat_chk = 1'b0;

    // Backpressure: three words fill the pipe, the fourth stalls.
    out_ready = 1'b0;
    send(8'h11, 1, rotl_model(8'h11, 1));
    send(8'hC3, 2, rotl_model(8'hC3, 2));
    send(8'h5E, 7, rotl_model(8'h5E, 7));
    in_data  = 8'h9A;
    in_amt   = 3'd4;
    drv_exp  = rotl_model(8'h9A, 4);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_hold", 32'(out_data), 32'(rotl_model(8'h11, 1)));
      chk("bp_count", 32'(sb_q.size()), 32'd3);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_acc();
    drain();

    // Reset with three words in flight: none of them may emerge.
    out_ready = 1'b0;
    send(8'h01, 1, rotl_model(8'h01, 1));
    send(8'h02, 2, rotl_model(8'h02, 2));
    send(8'h04, 3, rotl_model(8'h04, 3));
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_rst_no_output", 32'(sb_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // Random backpressure against the scoreboard.
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          logic [W-1:0] d;
          int a;
          d = W'($urandom_range(0, 255));
          a = $urandom_range(0, 7);
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          send(d, a, rotl_model(d, a));
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
